// File: rtl/instructie_ophaler_pkg.sv
// Processor-wide constants and fetch-stage state encoding shared by the fetch
// stage and the instruction decoder.
package instructie_ophaler_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 9;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h00;
    localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        GELDIG = 2'd2,
        STOP   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instructie_ophaler_if.sv
// Program-memory request/acknowledge bus between the fetch stage (master)
// and the program ROM (slave).
interface instructie_ophaler_if
    import instructie_ophaler_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int INSTR_WIDTH = INSTR_W
);
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/instructie_ophaler_programma_teller.sv
// Program counter: jump load takes priority over increment; the increment
// wraps modulo 2^ADDR_WIDTH without a carry flag.
module programma_teller
    import instructie_ophaler_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_ADDR;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instructie_ophaler.sv
// Instruction fetch stage: requests one word at a time from program memory
// and holds it in the instruction register until the decoder consumes it.
module instructie_ophaler
    import instructie_ophaler_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = ADDR_W,
    parameter int                     INSTR_WIDTH = INSTR_W,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = RESET_PC,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = HALT_WORD
) (
    input  logic                    clock,
    input  logic                    reset_n,
    instructie_ophaler_if.master    mem,
    input  logic                    sprong,
    input  logic [ADDR_WIDTH-1:0]   sprong_adres,
    input  logic                    stall,
    output logic [INSTR_WIDTH-1:0]  instructie,
    output logic                    instructie_geldig,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    gestopt
);

    fetch_state_t           state_reg, state_next;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic                   geldig_reg, geldig_next;
    logic                   gestopt_reg, gestopt_next;
    logic                   ir_load;
    logic                   pc_inc;
    logic                   pc_load;
    logic [ADDR_WIDTH-1:0]  pc_value;

    programma_teller #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_programma_teller (
        .clock      (clock),
        .reset_n    (reset_n),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (sprong_adres),
        .pc         (pc_value)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= START;
        end else begin
            state_reg <= state_next;
        end
    end

    // A jump outranks any ack or stall; START ignores it so reset release is clean.
    always_comb begin
        state_next   = state_reg;
        geldig_next  = geldig_reg;
        gestopt_next = gestopt_reg;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        if (state_reg != START && sprong) begin
            state_next   = FETCH;
            pc_load      = 1'b1;
            geldig_next  = 1'b0;
            gestopt_next = 1'b0;
        end else begin
            case (state_reg)
                START: state_next = FETCH;
                FETCH: begin
                    if (mem.mem_ack) begin
                        ir_load     = 1'b1;
                        pc_inc      = 1'b1;
                        geldig_next = 1'b1;
                        state_next  = GELDIG;
                    end
                end
                GELDIG: begin
                    if (!stall) begin
                        geldig_next = 1'b0;
                        if (instr_reg == HALT_OPCODE) begin
                            state_next   = STOP;
                            gestopt_next = 1'b1;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
                STOP: gestopt_next = 1'b1;
                default: state_next = START;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_reg   <= '0;
            geldig_reg  <= 1'b0;
            gestopt_reg <= 1'b0;
        end else begin
            if (ir_load) begin
                instr_reg <= mem.mem_data;
            end
            geldig_reg  <= geldig_next;
            gestopt_reg <= gestopt_next;
        end
    end

    assign mem.mem_req       = (state_reg == FETCH);
    assign mem.mem_addr      = pc_value;
    assign pc                = pc_value;
    assign instructie        = instr_reg;
    assign instructie_geldig = geldig_reg;
    assign gestopt           = gestopt_reg;

endmodule

// File: tb/tb_instructie_ophaler.sv
// Bench for instructie_ophaler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_instructie_ophaler;
    import instructie_ophaler_pkg::*;

    localparam int AW = 8;
    localparam int IW = 9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sprong = 1'b0;
    logic [AW-1:0] sprong_adres = '0;
    logic          stall = 1'b0;
    logic [IW-1:0] instructie;
    logic          instructie_geldig;
    logic [AW-1:0] pc;
    logic          gestopt;

    instructie_ophaler_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) mif ();

    instructie_ophaler #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_ADDR  (8'h00),
        .HALT_OPCODE (9'h1FF)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .mem               (mif),
        .sprong            (sprong),
        .sprong_adres      (sprong_adres),
        .stall             (stall),
        .instructie        (instructie),
        .instructie_geldig (instructie_geldig),
        .pc                (pc),
        .gestopt           (gestopt)
    );

    always #5 clock = ~clock;

    logic [IW-1:0] rom [256];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage is waiting for reset release, holding a word,
    // halted, or otherwise fetching from m_pc.
    bit            m_fresh  = 1'b1;
    bit            m_valid  = 1'b0;
    bit            m_halted = 1'b0;
    logic [AW-1:0] m_pc     = '0;
    logic [IW-1:0] m_instr  = '0;

    function automatic bit m_fetching();
        return !m_fresh && !m_valid && !m_halted;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_fresh = 1'b1; m_valid = 1'b0; m_halted = 1'b0; m_pc = '0; m_instr = '0;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (sprong) begin
            m_pc = sprong_adres; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_valid) begin
            if (!stall) begin
                m_valid = 1'b0;
                if (m_instr == 9'h1FF) m_halted = 1'b1;
            end
        end else if (!m_halted && mif.mem_ack) begin
            m_instr = rom[m_pc];
            m_valid = 1'b1;
            m_pc    = m_pc + 8'd1;
        end
    end

    always @(negedge clock) begin
        check("instructie", 32'(instructie), 32'(m_instr));
        check("geldig", 32'(instructie_geldig), 32'(m_valid));
        check("pc", 32'(pc), 32'(m_pc));
        check("gestopt", 32'(gestopt), 32'(m_halted));
        check("mem_req", 32'(mif.mem_req), 32'(m_fetching()));
        check("mem_addr", 32'(mif.mem_addr), 32'(m_pc));
    end

    // Stateless ROM: answers after mem_wait idle cycles, junk acks when idle.
    int mem_wait  = 0;
    int wait_cnt  = 0;
    bit rand_wait = 1'b0;
    bit junk_ack  = 1'b0;

    always @(negedge clock) begin
        if (reset_n && mif.mem_req) begin
            if (wait_cnt >= mem_wait) begin
                mif.mem_ack  = 1'b1;
                mif.mem_data = rom[mif.mem_addr];
                wait_cnt     = 0;
                if (rand_wait) mem_wait = $urandom_range(0, 3);
            end else begin
                mif.mem_ack  = 1'b0;
                mif.mem_data = 9'($urandom);
                wait_cnt++;
            end
        end else begin
            mif.mem_ack  = junk_ack && ($urandom_range(0, 1) == 1);
            mif.mem_data = 9'($urandom);
            wait_cnt     = 0;
        end
    end

    initial begin
        mif.mem_ack  = 1'b0;
        mif.mem_data = '0;
        for (int i = 0; i < 256; i++) rom[i] = 9'(i + 16);

        #2;
        check("rst_mem_req", 32'(mif.mem_req), 0);
        check("rst_mem_addr", 32'(mif.mem_addr), 0);
        check("rst_instructie", 32'(instructie), 0);
        check("rst_geldig", 32'(instructie_geldig), 0);
        check("rst_gestopt", 32'(gestopt), 0);

        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("first_req", 32'(mif.mem_req), 1);
        check("first_addr", 32'(mif.mem_addr), 0);
        @(negedge clock);
        check("word0", 32'(instructie), 32'h010);
        check("word0_pc", 32'(pc), 1);
        check("word0_geldig", 32'(instructie_geldig), 1);
        check("model_word0", 32'(m_instr), 32'h010);
        @(negedge clock);
        check("refetch_addr", 32'(mif.mem_addr), 1);
        @(negedge clock);
        check("word1", 32'(instructie), 32'h011);
        check("word1_pc", 32'(pc), 2);
        repeat (2) @(negedge clock);
        check("word2", 32'(instructie), 32'h012);
        check("word2_pc", 32'(pc), 3);
        repeat (2) @(negedge clock);
        check("word3", 32'(instructie), 32'h013);

        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_instr", 32'(instructie), 32'h013);
            check("stall_geldig", 32'(instructie_geldig), 1);
            check("stall_pc", 32'(pc), 4);
            check("stall_req", 32'(mif.mem_req), 0);
        end
        stall    = 1'b0;
        mem_wait = 3;

        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("wait_req", 32'(mif.mem_req), 1);
            check("wait_addr", 32'(mif.mem_addr), 4);
            check("wait_geldig", 32'(instructie_geldig), 0);
        end
        @(negedge clock);
        check("wait_word", 32'(instructie), 32'h014);
        check("wait_pc", 32'(pc), 5);
        mem_wait = 0;

        @(negedge clock);
        sprong = 1'b1; sprong_adres = 8'h40;
        @(negedge clock);
        check("jump_geldig", 32'(instructie_geldig), 0);
        check("jump_pc", 32'(pc), 32'h40);
        check("jump_addr", 32'(mif.mem_addr), 32'h40);
        check("jump_instr_kept", 32'(instructie), 32'h014);
        sprong_adres = 8'hFF;
        @(negedge clock);
        sprong = 1'b0;
        check("wrap_pre_pc", 32'(pc), 32'hFF);
        @(negedge clock);
        check("wrap_pc", 32'(pc), 0);
        check("wrap_word", 32'(instructie), 32'h10F);
        check("model_wrap_pc", 32'(m_pc), 0);
        @(negedge clock);
        check("wrap_addr", 32'(mif.mem_addr), 0);
        check("wrap_req", 32'(mif.mem_req), 1);

        rom[2] = 9'h1FF;
        sprong = 1'b1; sprong_adres = 8'h00;
        @(negedge clock);
        sprong = 1'b0;
        repeat (5) @(negedge clock);
        check("halt_held", 32'(instructie), 32'h1FF);
        check("halt_held_geldig", 32'(instructie_geldig), 1);
        check("halt_held_gestopt", 32'(gestopt), 0);
        @(negedge clock);
        check("halt_gestopt", 32'(gestopt), 1);
        check("halt_geldig", 32'(instructie_geldig), 0);
        check("halt_pc", 32'(pc), 3);
        check("model_halt", 32'(m_halted), 1);
        junk_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("halt_req", 32'(mif.mem_req), 0);
            check("halt_stay", 32'(gestopt), 1);
        end
        sprong = 1'b1; sprong_adres = 8'h00;
        @(negedge clock);
        sprong = 1'b0;
        rom[2] = 9'h012;
        check("resume_gestopt", 32'(gestopt), 0);
        check("resume_req", 32'(mif.mem_req), 1);
        check("resume_addr", 32'(mif.mem_addr), 0);

        #3 reset_n = 1'b0;
        #1;
        check("midrst_req", 32'(mif.mem_req), 0);
        check("midrst_geldig", 32'(instructie_geldig), 0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_instr", 32'(instructie), 0);
        @(negedge clock);
        #2 reset_n = 1'b1;

        rand_wait = 1'b1;
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            sprong       = ($urandom_range(0, 19) == 0);
            sprong_adres = 8'($urandom);
            stall        = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #($urandom_range(1, 3)) reset_n = 1'b0;
                #1;
                check("rand_rst_req", 32'(mif.mem_req), 0);
                check("rand_rst_geldig", 32'(instructie_geldig), 0);
                @(negedge clock);
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
